// File: rtl/time_setter.sv
// rtl/time_setter.sv - push-button date/time editor feeding the current-time counter
// Synchronises and debounces five buttons, then edits the date/time fields through a RUN/EDIT FSM.
module time_setter #(
  parameter int DEB_CYCLES = 2000000,
  parameter int YEAR_RST   = 2024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  output logic [14:0] year_d,
  output logic [3:0]  month_d,
  output logic [4:0]  day_d,
  output logic [5:0]  hour_d,
  output logic [5:0]  min_d,
  output logic [5:0]  sec_d,
  output logic [3:0]  week_s,
  output logic [3:0]  mode,
  output logic [2:0]  sel,
  output logic        load
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  typedef enum logic {RUN, EDIT} state_t;

  // Bit order: [4] middle, [3] left, [2] right, [1] up, [0] down.
  logic [4:0]    raw;
  logic [4:0]    sync1, sync2, stable, stable_q, press;
  logic [CW-1:0] cnt [5];
  state_t        state;
  logic          p_mid, p_left, p_right, p_up, p_down;

  assign raw = {middle, left, right, up, down};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 5; i++) begin
        // Any cycle where the synchronised level agrees with stable restarts the count.
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = stable & ~stable_q;

  always_comb begin
    p_mid   = press[4];
    p_left  = press[3] & ~press[4];
    p_right = press[2] & ~|press[4:3];
    p_up    = press[1] & ~|press[4:2];
    p_down  = press[0] & ~|press[4:1];
  end

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [14:0] y);
    logic leap;
    leap = ((y % 15'd4) == 15'd0 && (y % 15'd100) != 15'd0) || (y % 15'd400) == 15'd0;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  function automatic logic [14:0] step(input logic [14:0] v, input logic [14:0] lo,
                                       input logic [14:0] hi, input logic inc);
    if (inc) step = (v == hi) ? lo : v + 15'd1;
    else     step = (v == lo) ? hi : v - 15'd1;
  endfunction

  function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] dmax);
    clamp_day = (d > dmax) ? dmax : d;
  endfunction

  logic [14:0] year_n;
  logic [3:0]  month_n;
  logic [4:0]  day_max;

  always_comb begin
    year_n  = step(year_d, 15'd0, 15'd9999, p_up);
    month_n = 4'(step({11'd0, month_d}, 15'd1, 15'd12, p_up));
    day_max = days_in_month(month_d, year_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mode    <= 4'd0;
      sel     <= 3'd0;
      load    <= 1'b0;
      year_d  <= 15'(YEAR_RST);
      month_d <= 4'd1;
      day_d   <= 5'd1;
      hour_d  <= 6'd0;
      min_d   <= 6'd0;
      sec_d   <= 6'd0;
      week_s  <= 4'd1;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          if (p_mid) begin
            state <= EDIT;
            mode  <= 4'd1;
            sel   <= 3'd0;
          end
        end
        EDIT: begin
          if (p_mid) begin
            state <= RUN;
            mode  <= 4'd0;
            load  <= 1'b1;
          end else if (p_left) begin
            sel <= (sel == 3'd0) ? 3'd6 : sel - 3'd1;
          end else if (p_right) begin
            sel <= (sel == 3'd6) ? 3'd0 : sel + 3'd1;
          end else if (p_up || p_down) begin
            // Year/month changes clamp the day against the new month length in the same cycle.
            case (sel)
              3'd0: begin
                year_d <= year_n;
                day_d  <= clamp_day(day_d, days_in_month(month_d, year_n));
              end
              3'd1: begin
                month_d <= month_n;
                day_d   <= clamp_day(day_d, days_in_month(month_n, year_d));
              end
              3'd2: day_d  <= 5'(step({10'd0, day_d}, 15'd1, {10'd0, day_max}, p_up));
              3'd3: hour_d <= 6'(step({9'd0, hour_d}, 15'd0, 15'd23, p_up));
              3'd4: min_d  <= 6'(step({9'd0, min_d}, 15'd0, 15'd59, p_up));
              3'd5: sec_d  <= 6'(step({9'd0, sec_d}, 15'd0, 15'd59, p_up));
              3'd6: week_s <= 4'(step({11'd0, week_s}, 15'd1, 15'd7, p_up));
              default: ;
            endcase
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
